// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Purpose : Parametrised VESA-style raster timing generator. Divides the
//           system clock down to a pixel tick, runs the x/y raster counters,
//           decodes sync/blank and passes them through a pixel-tick-aligned
//           delay line so they line up with a pipelined colour path. Also
//           emits single-cycle line/frame/vblank event pulses.
// Ports   : clk            - system clock
//           rst_n          - asynchronous active-low reset
//           i_run          - 1 = raster advances, 0 = park generator
//           o_pix_en       - one-clk pulse per pixel tick
//           o_x, o_y       - current column / line (undelayed)
//           o_active       - visible-area flag from o_x/o_y (undelayed)
//           o_hsync        - delayed horizontal sync (polarity HS_POL)
//           o_vsync        - delayed vertical sync (polarity VS_POL)
//           o_de           - delayed data enable (blank_n)
//           o_line_start   - pulse when x wraps to 0
//           o_frame_start  - pulse when (x,y) wraps to (0,0)
//           o_vblank_start - pulse when y becomes V_ACTIVE
//           o_in_vblank    - level, y >= V_ACTIVE
// Revision: 1.0 - initial parametrised release
// ============================================================================
module vga_timing_gen #(
  parameter int CNT_W    = 11,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_DLY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  output logic             o_pix_en,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_active,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic             o_vblank_start,
  output logic             o_in_vblank
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] c_H_LAST     = CNT_W'(c_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_V_LAST     = CNT_W'(c_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_V_ACT_PREV = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] c_HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] c_VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [PIPE_DLY-1:0] c_HS_IDLE  = {PIPE_DLY{~HS_POL}};
  localparam logic [PIPE_DLY-1:0] c_VS_IDLE  = {PIPE_DLY{~VS_POL}};

  logic [c_DIV_W-1:0]  r_div_cnt;
  logic                r_pix_en;
  logic [CNT_W-1:0]    r_x;
  logic [CNT_W-1:0]    r_y;
  logic                r_line_start;
  logic                r_frame_start;
  logic                r_vblank_start;
  // Bit 0 is the newest stage; the MSB drives the outputs.
  logic [PIPE_DLY-1:0] r_hs_pipe;
  logic [PIPE_DLY-1:0] r_vs_pipe;
  logic [PIPE_DLY-1:0] r_de_pipe;

  logic w_div_last;
  logic w_x_wrap;
  logic w_y_wrap;
  logic w_active;
  logic w_hs_raw;
  logic w_vs_raw;

  assign w_div_last = (r_div_cnt == c_DIV_LAST);
  assign w_x_wrap   = (r_x == c_H_LAST);
  assign w_y_wrap   = (r_y == c_V_LAST);
  assign w_active   = (r_x < c_H_ACT) && (r_y < c_V_ACT);

  // Polarity is folded in before the delay line so every stage already
  // carries the pin level.
  assign w_hs_raw = ((r_x >= c_HS_START) && (r_x < c_HS_END)) ? HS_POL : ~HS_POL;
  assign w_vs_raw = ((r_y >= c_VS_START) && (r_y < c_VS_END)) ? VS_POL : ~VS_POL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt      <= '0;
      r_pix_en       <= 1'b0;
      r_x            <= '0;
      r_y            <= '0;
      r_line_start   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
      r_hs_pipe      <= c_HS_IDLE;
      r_vs_pipe      <= c_VS_IDLE;
      r_de_pipe      <= '0;
    end else if (!i_run) begin
      // Parked: identical to the reset state, so a later run rising edge
      // restarts exactly like a reset release.
      r_div_cnt      <= '0;
      r_pix_en       <= 1'b0;
      r_x            <= '0;
      r_y            <= '0;
      r_line_start   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
      r_hs_pipe      <= c_HS_IDLE;
      r_vs_pipe      <= c_VS_IDLE;
      r_de_pipe      <= '0;
    end else begin
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + c_DIV_W'(1);
      r_pix_en  <= w_div_last;

      if (r_pix_en) begin
        // Raster advances on the edge that closes a pix_en clk; the event
        // pulses are registered alongside so they appear with the new x/y.
        if (w_x_wrap) begin
          r_x <= '0;
          r_y <= w_y_wrap ? '0 : r_y + CNT_W'(1);
        end else begin
          r_x <= r_x + CNT_W'(1);
        end
        r_line_start   <= w_x_wrap;
        r_frame_start  <= w_x_wrap && w_y_wrap;
        r_vblank_start <= w_x_wrap && (r_y == c_V_ACT_PREV);

        // Sample decode of the position being left; delay counts pixel ticks.
        r_hs_pipe <= (r_hs_pipe << 1) | PIPE_DLY'(w_hs_raw);
        r_vs_pipe <= (r_vs_pipe << 1) | PIPE_DLY'(w_vs_raw);
        r_de_pipe <= (r_de_pipe << 1) | PIPE_DLY'(w_active);
      end else begin
        r_line_start   <= 1'b0;
        r_frame_start  <= 1'b0;
        r_vblank_start <= 1'b0;
      end
    end
  end

  assign o_pix_en       = r_pix_en;
  assign o_x            = r_x;
  assign o_y            = r_y;
  assign o_active       = w_active;
  assign o_hsync        = r_hs_pipe[PIPE_DLY-1];
  assign o_vsync        = r_vs_pipe[PIPE_DLY-1];
  assign o_de           = r_de_pipe[PIPE_DLY-1];
  assign o_line_start   = r_line_start;
  assign o_frame_start  = r_frame_start;
  assign o_vblank_start = r_vblank_start;
  assign o_in_vblank    = (r_y >= c_V_ACT);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_gen
// Purpose : Self-checking bench for vga_timing_gen. Two small raster modes
//           (divided clock with 2-tick delay, and undivided with 1-tick
//           delay and inverted polarities) share clk/rst_n/run. A closed-form
//           model derives every output from the number of clks since the
//           last reset/run release; a few literal measurements pin it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int CNT_W = 6;
  // Mode A: 15 x 10 total, CLK_DIV 3, PIPE_DLY 2, hsync low, vsync high
  localparam int A_HA = 8, A_HFP = 2, A_HS = 3, A_HBP = 2;
  localparam int A_VA = 5, A_VFP = 1, A_VS = 2, A_VBP = 2;
  localparam bit A_HP = 1'b0, A_VP = 1'b1;
  localparam int A_D = 3, A_P = 2;
  // Mode B: 12 x 8 total, CLK_DIV 1, PIPE_DLY 1, hsync high, vsync low
  localparam int B_HA = 6, B_HFP = 1, B_HS = 2, B_HBP = 3;
  localparam int B_VA = 4, B_VFP = 2, B_VS = 1, B_VBP = 1;
  localparam bit B_HP = 1'b1, B_VP = 1'b0;
  localparam int B_D = 1, B_P = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run = 1'b0;
  always #5 clk = ~clk;

  logic             a_pe, a_act, a_hs, a_vs, a_de, a_ls, a_fs, a_vbs, a_ivb;
  logic [CNT_W-1:0] a_x, a_y;
  logic             b_pe, b_act, b_hs, b_vs, b_de, b_ls, b_fs, b_vbs, b_ivb;
  logic [CNT_W-1:0] b_x, b_y;

  vga_timing_gen #(
    .CNT_W(CNT_W), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .HS_POL(A_HP), .VS_POL(A_VP), .CLK_DIV(A_D), .PIPE_DLY(A_P)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_run(run), .o_pix_en(a_pe), .o_x(a_x), .o_y(a_y),
    .o_active(a_act), .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
    .o_line_start(a_ls), .o_frame_start(a_fs), .o_vblank_start(a_vbs),
    .o_in_vblank(a_ivb)
  );

  vga_timing_gen #(
    .CNT_W(CNT_W), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .HS_POL(B_HP), .VS_POL(B_VP), .CLK_DIV(B_D), .PIPE_DLY(B_P)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_run(run), .o_pix_en(b_pe), .o_x(b_x), .o_y(b_y),
    .o_active(b_act), .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
    .o_line_start(b_ls), .o_frame_start(b_fs), .o_vblank_start(b_vbs),
    .o_in_vblank(b_ivb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    bit pe; int x; int y; bit act; bit hs; bit vs; bit de;
    bit ls; bit fs; bit vbs; bit ivb;
  } exp_t;

  // c = clk edges since the last reset/run release (0 = parked/reset).
  // Pixel position index t = ticks completed; delayed outputs show t-PIPE_DLY.
  function automatic exp_t model(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
                                 input bit hp, vp, input int d, p, input longint c);
    exp_t   e;
    longint ht, vt, t, q;
    int     xd, yd;
    bit     adv;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    t  = (c == 0) ? 0 : (c - 1) / d;
    e.x   = int'(t % ht);
    e.y   = int'((t / ht) % vt);
    e.pe  = (c >= 1) && (c % d == 0);
    e.act = (e.x < ha) && (e.y < va);
    e.ivb = (e.y >= va);
    adv   = (c >= 2) && ((c - 1) % d == 0);
    e.ls  = adv && (e.x == 0);
    e.fs  = e.ls && (e.y == 0);
    e.vbs = e.ls && (e.y == va);
    if (t >= p) begin
      q  = t - p;
      xd = int'(q % ht);
      yd = int'((q / ht) % vt);
      e.hs = (xd >= ha + hfp && xd < ha + hfp + hsw) ? hp : !hp;
      e.vs = (yd >= va + vfp && yd < va + vfp + vsw) ? vp : !vp;
      e.de = (xd < ha) && (yd < va);
    end else begin
      e.hs = !hp;
      e.vs = !vp;
      e.de = 1'b0;
    end
    return e;
  endfunction

  longint c = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    c <= 0;
    else if (!run) c <= 0;
    else           c <= c + 1;
  end

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    exp_t ea, eb;
    ea = model(A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_HP, A_VP, A_D, A_P, c);
    eb = model(B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_HP, B_VP, B_D, B_P, c);
    chk("A.pix_en", a_pe, ea.pe);  chk("A.x", a_x, ea.x);   chk("A.y", a_y, ea.y);
    chk("A.active", a_act, ea.act); chk("A.hsync", a_hs, ea.hs); chk("A.vsync", a_vs, ea.vs);
    chk("A.de", a_de, ea.de);      chk("A.line_start", a_ls, ea.ls);
    chk("A.frame_start", a_fs, ea.fs); chk("A.vblank_start", a_vbs, ea.vbs);
    chk("A.in_vblank", a_ivb, ea.ivb);
    chk("B.pix_en", b_pe, eb.pe);  chk("B.x", b_x, eb.x);   chk("B.y", b_y, eb.y);
    chk("B.active", b_act, eb.act); chk("B.hsync", b_hs, eb.hs); chk("B.vsync", b_vs, eb.vs);
    chk("B.de", b_de, eb.de);      chk("B.line_start", b_ls, eb.ls);
    chk("B.frame_start", b_fs, eb.fs); chk("B.vblank_start", b_vbs, eb.vbs);
    chk("B.in_vblank", b_ivb, eb.ivb);
  end

  task automatic check_reset(input string tag);
    chk({tag, " A.x"}, a_x, 0);       chk({tag, " A.y"}, a_y, 0);
    chk({tag, " A.pix_en"}, a_pe, 0); chk({tag, " A.hsync"}, a_hs, 1);
    chk({tag, " A.vsync"}, a_vs, 0);  chk({tag, " A.de"}, a_de, 0);
    chk({tag, " A.pulses"}, {a_ls, a_fs, a_vbs}, 0);
    chk({tag, " B.x"}, b_x, 0);       chk({tag, " B.pix_en"}, b_pe, 0);
    chk({tag, " B.hsync"}, b_hs, 0);  chk({tag, " B.vsync"}, b_vs, 1);
    chk({tag, " B.de"}, b_de, 0);     chk({tag, " B.pulses"}, {b_ls, b_fs, b_vbs}, 0);
  endtask

  initial begin
    int fpe_a, fde_a, fs1_a, fs2_a, ls_a, vbs_a, hs_a, vs_a, de_a, vb_a;
    int fpe_b, fde_b, fs1_b, fs2_b, ls_b, hs_b, vs_b, de_b;
    int found, nfs;
    fpe_a = -1; fde_a = -1; fs1_a = -1; fs2_a = -1;
    ls_a = 0; vbs_a = 0; hs_a = 0; vs_a = 0; de_a = 0; vb_a = 0;
    fpe_b = -1; fde_b = -1; fs1_b = -1; fs2_b = -1;
    ls_b = 0; hs_b = 0; vs_b = 0; de_b = 0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // Release reset and run two frames of each mode, measuring by hand.
    run   = 1'b1;
    rst_n = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_pe && fpe_a < 0) fpe_a = n;
      if (a_de && fde_a < 0) fde_a = n;
      if (fs1_a >= 0 && fs2_a < 0) begin
        if (a_ls)  ls_a++;
        if (a_vbs) vbs_a++;
        if (a_pe) begin
          if (!a_hs) hs_a++;
          if (a_vs)  vs_a++;
          if (a_de)  de_a++;
          if (a_ivb) vb_a++;
        end
      end
      if (a_fs) begin
        if (fs1_a < 0) fs1_a = n; else if (fs2_a < 0) fs2_a = n;
      end
      if (b_pe && fpe_b < 0) fpe_b = n;
      if (b_de && fde_b < 0) fde_b = n;
      if (fs1_b >= 0 && fs2_b < 0) begin
        if (b_ls) ls_b++;
        if (b_pe) begin
          if (b_hs)  hs_b++;
          if (!b_vs) vs_b++;
          if (b_de)  de_b++;
        end
      end
      if (b_fs) begin
        if (fs1_b < 0) fs1_b = n; else if (fs2_b < 0) fs2_b = n;
      end
    end
    chk("A.first_pix_en_clk", fpe_a, 3);
    chk("A.first_de_clk", fde_a, 7);
    chk("A.first_frame_start_clk", fs1_a, 451);
    chk("A.frame_period_clks", fs2_a - fs1_a, 450);
    chk("A.lines_per_frame", ls_a, 10);
    chk("A.vblank_starts_per_frame", vbs_a, 1);
    chk("A.hsync_active_ticks", hs_a, 30);
    chk("A.vsync_active_ticks", vs_a, 30);
    chk("A.de_ticks", de_a, 40);
    chk("A.in_vblank_ticks", vb_a, 75);
    chk("B.first_pix_en_clk", fpe_b, 1);
    chk("B.first_de_clk", fde_b, 2);
    chk("B.first_frame_start_clk", fs1_b, 97);
    chk("B.frame_period_clks", fs2_b - fs1_b, 96);
    chk("B.lines_per_frame", ls_b, 8);
    chk("B.hsync_active_ticks", hs_b, 16);
    chk("B.vsync_active_ticks", vs_b, 12);
    chk("B.de_ticks", de_b, 24);

    // Park mid-frame at A (5,3), then restart and time the first frame.
    found = 0;
    for (int n = 0; n < 2000 && found == 0; n++) begin
      @(negedge clk);
      if (a_x == 5 && a_y == 3) found = 1;
    end
    chk("A.reached_x5_y3", found, 1);
    run = 1'b0;
    @(negedge clk);
    chk("park A.x", a_x, 0);      chk("park A.y", a_y, 0);
    chk("park A.hsync", a_hs, 1); chk("park A.vsync", a_vs, 0);
    chk("park A.de", a_de, 0);
    repeat (5) @(negedge clk);
    check_reset("parked");
    run = 1'b1;
    nfs = -1;
    for (int n = 1; n <= 1000 && nfs < 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_fs) nfs = n;
    end
    chk("A.restart_frame_start_clk", nfs, 451);

    // Randomised run drops and asynchronous reset pulses.
    for (int k = 0; k < 50; k++) begin
      repeat ($urandom_range(20, 400)) @(negedge clk);
      case ($urandom_range(0, 2))
        0: begin
          run = 1'b0;
          repeat ($urandom_range(1, 15)) @(negedge clk);
          run = 1'b1;
        end
        1: begin
          #($urandom_range(1, 2));
          rst_n = 1'b0;
          #1 check_reset("async_pulse");
          #1 rst_n = 1'b1;
        end
        default: begin
          #2 rst_n = 1'b0;
          #1 check_reset("async_hold");
          repeat ($urandom_range(1, 4)) @(negedge clk);
          #2 rst_n = 1'b1;
        end
      endcase
    end
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA timing generator.
- Produces the raster counters, a pixel clock enable and the sync/blank outputs for any VESA-style mode from one system clock.
- Adds programmable sync polarity, a pixel-tick-aligned output delay line so sync matches a pipelined colour path, a synchronous run/stop control, and single-cycle line, frame and vblank event pulses for game logic.

Parameters:
- CNT_W, 11, width of the x/y counters; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- HS_POL, 0, active level of hsync (0 = active-low).
- VS_POL, 0, active level of vsync.
- CLK_DIV, 2, clk cycles per pixel; must be >=1.
- PIPE_DLY, 2, pixel ticks of delay on hsync/vsync/de relative to x/y; must be >=1.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- run, in, 1, 1 = raster advances; 0 = synchronously park the generator.
- pix_en, out, 1, one-clk pulse per pixel tick.
- x, out, CNT_W, current column (undelayed).
- y, out, CNT_W, current line (undelayed).
- active, out, 1, x<H_ACTIVE && y<V_ACTIVE (undelayed, combinational from x/y).
- hsync, out, 1, delayed horizontal sync.
- vsync, out, 1, delayed vertical sync.
- de, out, 1, delayed data enable; VGA_BLANK_N equivalent.
- line_start, out, 1, one-clk pulse when x wraps to 0.
- frame_start, out, 1, one-clk pulse when (x,y) wraps to (0,0).
- vblank_start, out, 1, one-clk pulse when y becomes V_ACTIVE.
- in_vblank, out, 1, level: y>=V_ACTIVE.

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL similarly (default 525).
- Horizontal sync region: x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- Vertical sync region: y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Reset (rst=0, asynchronous) clears everything:
  - div_cnt=0, x=0, y=0, pix_en=0.
  - line_start, frame_start and vblank_start = 0.
  - hsync=~HS_POL, vsync=~VS_POL, de=0.
  - All delay-line stages are loaded with the inactive values.
- Divider behaviour:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered; it is 1 for exactly one clk when div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pix_en=1 every clk after reset release.
  - The first pix_en occurs CLK_DIV clks after reset release.
- Counter behaviour:
  - x and y update only on clks where pix_en=1.
  - When x==H_TOTAL-1: x<=0, and y increments, or wraps to 0 if y==V_TOTAL-1.
  - Otherwise x<=x+1.
  - No other counter transitions exist; out-of-range values are unreachable.
- Event pulses:
  - All are registered, one clk wide, and coincide with the clk in which the new x/y values become visible.
  - line_start: new x==0.
  - frame_start: new x==0 and new y==0.
  - vblank_start: new x==0 and new y==V_ACTIVE.
  - At a frame wrap, line_start and frame_start assert in the same clk.
- Delay line:
  - Decoded raw hs/vs/de from the current x/y are shifted through PIPE_DLY stages.
  - The line shifts only on pix_en, so the delay equals PIPE_DLY pixel ticks regardless of CLK_DIV.
  - hsync, vsync and de are the final stage; polarity is applied before the first stage.
- run=0:
  - On the next clk: div_cnt, x and y go to 0, pix_en=0, and pulses go to 0.
  - The delay line is flushed to the inactive values on that same clk.
  - All of these values hold while run=0.
- run rising:
  - Behaves exactly as a reset release: first pix_en after CLK_DIV clks, and no frame_start is emitted for the initial (0,0).
- Reset mid-frame: asynchronous clear to the reset state; no partial pulses.
- run and rst are not mutually constrained; rst dominates.

Test Plan:
- Defaults, run=1, 2 full frames:
  - pix_en has period 2 clks.
  - hsync is low for 96 pixel ticks starting at delayed x=656; line period is 800 ticks.
  - vsync is low for lines 490-491; frame period is 525 lines = 840000 clks.
  - de is high for 640x480 ticks per frame.
- Delay alignment, defaults:
  - The first de rising edge after frame_start occurs exactly PIPE_DLY=2 pix_en pulses after x=0,y=0 becomes visible.
  - With PIPE_DLY=1, it occurs 1 pulse after.
- Events:
  - Count exactly 525 line_start pulses per frame_start.
  - vblank_start fires once per frame, the same clk that y becomes 480.
  - in_vblank is high for y=480..524.
- Parametric mode, 800x600@60 (H 800/40/128/88, V 600/1/4/23, HS_POL=VS_POL=1, CLK_DIV=1):
  - Line = 1056 clks, frame = 628 lines.
  - hsync is high for x 840..967 (delayed).
- run deasserted at x=300,y=100:
  - Next clk: x=y=0, hsync=vsync=inactive, de=0.
  - After run=1: first pix_en after CLK_DIV clks; the first frame_start occurs 420000 pixel ticks later (defaults).
- Async reset pulse mid-line (not clk-aligned):
  - All outputs reach reset values immediately.
  - No glitch pulse on line_start, frame_start or vblank_start.
